// File: rtl/ul_cpu_arb_pkg.sv
// Shared definitions for the two-requester CPU register bus arbiter:
// FSM state encoding, latency counter width and requester count.
package ul_cpu_arb_pkg;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned N_REQ = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_ACK   = 2'd3
   } arb_state_t;

   // Counter preload: WAIT runs until the counter reaches zero, so load RD_LAT-1.
   function automatic logic [CNT_W-1:0] rd_lat_load(input int unsigned rd_lat);
      return CNT_W'(rd_lat - 32'd1);
   endfunction

endpackage

// File: rtl/ul_rr_arb2.sv
// Two-way round-robin grant.
// Ports:
//   i_req      - request vector, bit 0 = m0, bit 1 = m1
//   i_last_gnt - requester granted last (1 = m1), decides contention
//   o_gnt_c    - one-hot grant (combinational), zero when nobody requests
module ul_rr_arb2
   import ul_cpu_arb_pkg::*;
(
   input  logic [N_REQ-1:0] i_req,
   input  logic             i_last_gnt,
   output logic [N_REQ-1:0] o_gnt_c
);

   // Single requester wins outright; on contention the one not granted last wins.
   always_comb begin
      o_gnt_c = '0;
      case (i_req)
         2'b01:   o_gnt_c = 2'b01;
         2'b10:   o_gnt_c = 2'b10;
         2'b11:   o_gnt_c = i_last_gnt ? 2'b01 : 2'b10;
         default: o_gnt_c = 2'b00;
      endcase
   end

endmodule

// File: rtl/ul_cpu_bus_arb.sv
// Arbitrates two level-handshake requesters onto one CPU register bus,
// one transaction in flight at a time.
// Ports:
//   clk_200m, rst_200m            - clock, synchronous active-high reset
//   mX_req/wr/addr/wdata          - requester X transaction (held until mX_ack)
//   mX_ack, mX_rdata              - one-cycle completion pulse, captured read data
//   cpu_wr, cpu_rd                - one-cycle register strobes
//   cpu_addr, cpu_data_in         - registered address / write data
//   cpu_data_out                  - read data, valid RD_LAT cycles after cpu_rd
//   busy                          - high whenever the FSM is outside IDLE
module ul_cpu_bus_arb
   import ul_cpu_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned RD_LAT     = 2
)(
   input  logic                  clk_200m,
   input  logic                  rst_200m,
   input  logic                  m0_req,
   input  logic                  m0_wr,
   input  logic [ADDR_WIDTH-1:0] m0_addr,
   input  logic [DATA_WIDTH-1:0] m0_wdata,
   output logic                  m0_ack,
   output logic [DATA_WIDTH-1:0] m0_rdata,
   input  logic                  m1_req,
   input  logic                  m1_wr,
   input  logic [ADDR_WIDTH-1:0] m1_addr,
   input  logic [DATA_WIDTH-1:0] m1_wdata,
   output logic                  m1_ack,
   output logic [DATA_WIDTH-1:0] m1_rdata,
   output logic                  cpu_wr,
   output logic                  cpu_rd,
   output logic [ADDR_WIDTH-1:0] cpu_addr,
   output logic [DATA_WIDTH-1:0] cpu_data_in,
   input  logic [DATA_WIDTH-1:0] cpu_data_out,
   output logic                  busy
);

   arb_state_t            r_state;
   arb_state_t            w_state_nxt;
   logic [N_REQ-1:0]      w_req;
   logic [N_REQ-1:0]      w_gnt;
   logic                  w_start;
   logic                  w_capture;
   logic                  w_sel_wr;
   logic [ADDR_WIDTH-1:0] w_sel_addr;
   logic [DATA_WIDTH-1:0] w_sel_wdata;

   logic                  r_last_gnt;   // 1 = m1 granted last
   logic                  r_owner;      // 1 = m1 owns the transaction
   logic                  r_wr;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_cpu_wr;
   logic                  r_cpu_rd;
   logic [ADDR_WIDTH-1:0] r_cpu_addr;
   logic [DATA_WIDTH-1:0] r_cpu_data_in;
   logic                  r_m0_ack;
   logic                  r_m1_ack;
   logic [DATA_WIDTH-1:0] r_m0_rdata;
   logic [DATA_WIDTH-1:0] r_m1_rdata;
   logic                  r_busy;

   assign w_req = {m1_req, m0_req};

   ul_rr_arb2 u_rr_arb2 (
      .i_req      (w_req),
      .i_last_gnt (r_last_gnt),
      .o_gnt_c    (w_gnt)
   );

   // Winner payload mux; grant is one-hot so an AND-OR select suffices.
   assign w_sel_wr    = (w_gnt[0] & m0_wr) | (w_gnt[1] & m1_wr);
   assign w_sel_addr  = ({ADDR_WIDTH{w_gnt[0]}} & m0_addr)  | ({ADDR_WIDTH{w_gnt[1]}} & m1_addr);
   assign w_sel_wdata = ({DATA_WIDTH{w_gnt[0]}} & m0_wdata) | ({DATA_WIDTH{w_gnt[1]}} & m1_wdata);

   // State register.
   always_ff @(posedge clk_200m) begin
      if (rst_200m) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state and control decode.
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|w_req) begin
               w_start     = 1'b1;
               w_state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: w_state_nxt = r_wr ? ST_ACK : ST_WAIT;
         ST_WAIT: begin
            if (r_cnt == '0) begin
               w_capture   = 1'b1;
               w_state_nxt = ST_ACK;
            end
         end
         ST_ACK:  w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Registered datapath and outputs; strobes/acks are decoded from the next state
   // so they line up with the ISSUE/ACK cycles.
   always_ff @(posedge clk_200m) begin
      if (rst_200m) begin
         r_last_gnt    <= 1'b1;
         r_owner       <= 1'b0;
         r_wr          <= 1'b0;
         r_cnt         <= '0;
         r_cpu_wr      <= 1'b0;
         r_cpu_rd      <= 1'b0;
         r_cpu_addr    <= '0;
         r_cpu_data_in <= '0;
         r_m0_ack      <= 1'b0;
         r_m1_ack      <= 1'b0;
         r_m0_rdata    <= '0;
         r_m1_rdata    <= '0;
         r_busy        <= 1'b0;
      end else begin
         r_cpu_wr <= w_start &  w_sel_wr;
         r_cpu_rd <= w_start & ~w_sel_wr;
         r_m0_ack <= (w_state_nxt == ST_ACK) && (r_state != ST_ACK) && !r_owner;
         r_m1_ack <= (w_state_nxt == ST_ACK) && (r_state != ST_ACK) &&  r_owner;
         r_busy   <= (w_state_nxt != ST_IDLE);

         if (w_start) begin
            r_owner       <= w_gnt[1];
            r_last_gnt    <= w_gnt[1];
            r_wr          <= w_sel_wr;
            r_cpu_addr    <= w_sel_addr;
            r_cpu_data_in <= w_sel_wdata;
         end

         if ((r_state == ST_ISSUE) && !r_wr)
            r_cnt <= rd_lat_load(RD_LAT);
         else if ((r_state == ST_WAIT) && (r_cnt != '0))
            r_cnt <= r_cnt - CNT_W'(1);

         if (w_capture) begin
            if (r_owner) r_m1_rdata <= cpu_data_out;
            else         r_m0_rdata <= cpu_data_out;
         end
      end
   end

   assign cpu_wr      = r_cpu_wr;
   assign cpu_rd      = r_cpu_rd;
   assign cpu_addr    = r_cpu_addr;
   assign cpu_data_in = r_cpu_data_in;
   assign m0_ack      = r_m0_ack;
   assign m1_ack      = r_m1_ack;
   assign m0_rdata    = r_m0_rdata;
   assign m1_rdata    = r_m1_rdata;
   assign busy        = r_busy;

endmodule

// File: doc/ul_cpu_bus_arb.md
UL_CPU_BUS_ARB -- requirements
Module: ul_cpu_bus_arb

Interface
REQ-001 Parameters, one per line: name, default, meaning:
- ADDR_WIDTH, 32, requester and CPU bus address width.
- DATA_WIDTH, 32, data width.
- RD_LAT, 2, fixed cycles from the cpu_rd cycle to valid cpu_data_out; legal range 1..15.

REQ-002 Ports, one per line: name, direction, width, meaning:
- clk_200m, in, 1, sole clock.
- rst_200m, in, 1, synchronous active-high reset.
- m0_req, in, 1, requester 0 transaction request; level signal held until m0_ack.
- m0_wr, in, 1, requester 0 type: 1 = write, 0 = read; stable while m0_req is high.
- m0_addr, in, ADDR_WIDTH, requester 0 address; stable while m0_req is high.
- m0_wdata, in, DATA_WIDTH, requester 0 write data; stable while m0_req is high.
- m0_ack, out, 1, one-cycle completion pulse to requester 0.
- m0_rdata, out, DATA_WIDTH, requester 0 read data; valid when m0_ack is high on a read.
- m1_req, m1_wr, m1_addr, m1_wdata, m1_ack, m1_rdata: same directions, widths and meanings for requester 1.
- cpu_wr, out, 1, one-cycle register write strobe.
- cpu_rd, out, 1, one-cycle register read strobe.
- cpu_addr, out, ADDR_WIDTH, register address.
- cpu_data_in, out, DATA_WIDTH, register write data.
- cpu_data_out, in, DATA_WIDTH, register read data, valid RD_LAT cycles after cpu_rd.
- busy, out, 1, high whenever the FSM is not in IDLE.

Function
REQ-003 FSM states: IDLE, ISSUE, WAIT, ACK; one transaction is in flight at a time.
REQ-004 IDLE: if any mX_req is high, select a winner, register its wr/addr/wdata and the owner index, then go to ISSUE; otherwise stay in IDLE.
REQ-005 Arbitration: a single request wins outright; if both are requesting, the requester not granted last wins (round-robin); after reset, m0 has priority.
REQ-006 ISSUE lasts exactly one cycle and asserts cpu_wr (write) or cpu_rd (read) only in that cycle.
- Write: go to ACK.
- Read: go to WAIT and load the latency counter.
REQ-007 cpu_addr and cpu_data_in are registered and hold their values from ISSUE until the next ISSUE.
REQ-008 Read timing: with cpu_rd in cycle T, capture cpu_data_out at the end of cycle T+RD_LAT into the owner's rdata register; ACK is cycle T+RD_LAT+1. The 4-bit counter covers RD_LAT up to 15.
REQ-009 Write timing: with cpu_wr in cycle T, ACK is cycle T+1.
REQ-010 ACK: pulse the owner's mX_ack for exactly one cycle, then go to IDLE; the other requester's ack stays low.
REQ-011 Latency from a req seen in IDLE cycle C: strobe in C+1; write ack in C+2. Minimum write cost is 3 cycles including IDLE; the next strobe can occur no earlier than C+4.
REQ-012 mX_rdata is updated only on that requester's read capture and holds otherwise; writes leave it unchanged.
REQ-013 Arbitration inputs are ignored outside IDLE. A req change during a transaction does not abort it; ack is still issued.
REQ-014 A requester whose req stays high after its ack is treated as a new request in the following IDLE cycle.
REQ-015 cpu_wr and cpu_rd are never high in the same cycle.

Reset
REQ-016 On rst_200m:
- FSM goes to IDLE.
- cpu_wr, cpu_rd, m0_ack, m1_ack and busy are 0.
- cpu_addr, cpu_data_in, m0_rdata and m1_rdata are 0.
- The round-robin pointer selects m0 first.
- The latency counter is 0.
REQ-017 Reset mid-transaction drops the transaction; no ack or strobe is issued after reset deasserts until a new request arrives.

Structure
REQ-018 The shared package/header ul_cpu_arb_pkg holds the FSM state encodings and the counter width constant (4).
REQ-019 The two-way round-robin grant logic is a sub-module, ul_rr_arb2 (inputs: req[1:0], last-grant pointer; output: one-hot grant).

Verification
REQ-020 m0 writes addr 0x10, data 0xA5A5A5A5 -> cpu_wr pulse at C+1 with cpu_addr=0x10 and cpu_data_in=0xA5A5A5A5; m0_ack at C+2; m1_ack stays 0.
REQ-021 m1 reads with RD_LAT=2 and the model returns 0x12345678 at T+2 -> m1_ack at T+3 with m1_rdata=0x12345678; busy high for 4 cycles.
REQ-022 m0 and m1 request in the same cycle, both held for 4 transactions -> grants alternate m0, m1, m0, m1; no two strobes closer than 3 cycles.
REQ-023 Assert rst_200m during WAIT of a read -> all outputs 0 the next cycle, no ack; a subsequent m1+m0 simultaneous request grants m0.
REQ-024 RD_LAT=15 read -> ack exactly 16 cycles after cpu_rd; a RD_LAT=1 build gives ack 2 cycles after cpu_rd.
